// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable data width, parity and stop bits, plus a one-word holding register.
// Optional break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_frame #(
    parameter int unsigned CLKS_PER_BIT = 48,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
`ifdef UART_TX_BREAK_EN
    input  logic                 i_Tx_Break,
`endif
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Data,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    if (PARITY_MODE > 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 2) begin : g_bad_params
        $error("uart_tx_frame: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state, next_state;
    logic [CW-1:0]        clk_cnt, next_cnt;
    logic [IW-1:0]        bit_idx, next_idx;
    logic                 stop_cnt, next_stop;
    logic [DATA_BITS-1:0] shift_reg, hold_data;
    logic                 hold_full, accept, load, bit_end;
    logic                 line_next, active_next, done_next;
    logic                 brk_req, brk_block;

    assign accept     = i_Tx_DV & ~hold_full;
    assign o_Tx_Ready = ~hold_full;
    assign bit_end    = (clk_cnt == CNT_LAST);

`ifdef UART_TX_BREAK_EN
    logic          brk_hold;
    logic [CW-1:0] mark_cnt;

    assign brk_req   = i_Tx_Break;
    assign brk_block = i_Tx_Break | brk_hold;

    // After break releases, hold off new frames for one full bit time of mark.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            brk_hold <= 1'b0;
            mark_cnt <= '0;
        end else if (state == S_IDLE && i_Tx_Break) begin
            brk_hold <= 1'b1;
            mark_cnt <= '0;
        end else if (brk_hold) begin
            if (mark_cnt == CNT_LAST) begin
                brk_hold <= 1'b0;
            end
            mark_cnt <= mark_cnt + 1'b1;
        end
    end
`else
    assign brk_req   = 1'b0;
    assign brk_block = 1'b0;
`endif

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state    <= S_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            state    <= next_state;
            clk_cnt  <= next_cnt;
            bit_idx  <= next_idx;
            stop_cnt <= next_stop;
        end
    end

    // A word accepted on the final stop cycle bypasses the holding register.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= hold_full ? hold_data : i_Tx_Data;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_data <= i_Tx_Data;
            hold_full <= 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Serial <= line_next;
            o_Tx_Active <= active_next;
            o_Tx_Done   <= done_next;
        end
    end

    always_comb begin
        next_state  = state;
        next_cnt    = clk_cnt;
        next_idx    = bit_idx;
        next_stop   = stop_cnt;
        load        = 1'b0;
        line_next   = 1'b1;
        active_next = 1'b1;
        done_next   = 1'b0;
        case (state)
            S_IDLE: begin
                active_next = 1'b0;
                line_next   = ~brk_req;
                next_cnt    = '0;
                if (hold_full && !brk_block) begin
                    load       = 1'b1;
                    next_state = S_START;
                end
            end
            S_START: begin
                line_next = 1'b0;
                next_cnt  = bit_end ? '0 : clk_cnt + 1'b1;
                if (bit_end) begin
                    next_idx   = '0;
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                line_next = shift_reg[bit_idx];
                next_cnt  = bit_end ? '0 : clk_cnt + 1'b1;
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
                        next_stop  = 1'b0;
                        next_state = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        next_idx = bit_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                line_next = (PARITY_MODE == 1) ? ~(^shift_reg) : ^shift_reg;
                next_cnt  = bit_end ? '0 : clk_cnt + 1'b1;
                if (bit_end) begin
                    next_stop  = 1'b0;
                    next_state = S_STOP;
                end
            end
            S_STOP: begin
                next_cnt = bit_end ? '0 : clk_cnt + 1'b1;
                if (bit_end) begin
                    if (stop_cnt == STOP_LAST) begin
                        done_next = 1'b1;
                        if ((hold_full || accept) && !brk_block) begin
                            load       = 1'b1;
                            next_state = S_START;
                        end else begin
                            next_state = S_IDLE;
                        end
                    end else begin
                        next_stop = 1'b1;
                    end
                end
            end
            default: begin
                next_state  = S_IDLE;
                next_cnt    = '0;
                active_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a line-level frame model checks the 8N1 instance every cycle,
// and directed vectors with literal expectations cover parity, back-to-back, reset and break.
module tb_uart_tx_frame;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dv = 1'b0;
    logic [7:0] data = '0;
    logic dvp = 1'b0;
    logic [6:0] d7 = '0;
    logic ser, act, done, rdy;
    logic pe_ser, pe_act, pe_done, pe_rdy;
    logic po_ser, po_act, po_done, po_rdy;
`ifdef UART_TX_BREAK_EN
    logic brk = 1'b0;
    logic brk_off = 1'b0;
    logic [127:0] sch_brk = '0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut (
        .i_Clock(clk), .i_Reset_n(rst_n),
`ifdef UART_TX_BREAK_EN
        .i_Tx_Break(brk),
`endif
        .i_Tx_DV(dv), .i_Tx_Data(data), .o_Tx_Ready(rdy), .o_Tx_Active(act),
        .o_Tx_Serial(ser), .o_Tx_Done(done));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_even (
        .i_Clock(clk), .i_Reset_n(rst_n),
`ifdef UART_TX_BREAK_EN
        .i_Tx_Break(brk_off),
`endif
        .i_Tx_DV(dvp), .i_Tx_Data(d7), .o_Tx_Ready(pe_rdy), .o_Tx_Active(pe_act),
        .o_Tx_Serial(pe_ser), .o_Tx_Done(pe_done));

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_odd (
        .i_Clock(clk), .i_Reset_n(rst_n),
`ifdef UART_TX_BREAK_EN
        .i_Tx_Break(brk_off),
`endif
        .i_Tx_DV(dvp), .i_Tx_Data(d7), .o_Tx_Ready(po_rdy), .o_Tx_Active(po_act),
        .o_Tx_Serial(po_ser), .o_Tx_Done(po_done));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Per-cycle line values of one 8N1 frame, LSB = first cycle on the line.
    function automatic logic [39:0] frame_of(input logic [7:0] w);
        logic [39:0] f;
        int p;
        f = '0;
        p = 0;
        for (int c = 0; c < CPB; c++) begin f[p] = 1'b0; p++; end
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < CPB; c++) begin f[p] = w[b]; p++; end
        for (int c = 0; c < CPB; c++) begin f[p] = 1'b1; p++; end
        return f;
    endfunction

    // Model: a word waits in the holding slot; a frame is queued onto the line once the
    // line is free, or directly when the word arrives as the previous frame's last cycle leaves.
    logic [39:0] m_fbits;
    int          m_fleft;
    logic        m_full, m_ser, m_act, m_done, m_valid, m_acc, m_last;
    logic [7:0]  m_word;
    logic        model_on = 1'b1;

    initial begin
        m_valid = 1'b0;
        m_full = 1'b0;
        m_fleft = 0;
        m_fbits = '0;
        m_word = '0;
        m_ser = 1'b1; m_act = 1'b0; m_done = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_fleft = 0; m_full = 1'b0;
                m_ser = 1'b1; m_act = 1'b0; m_done = 1'b0;
                m_valid = 1'b1;
            end else begin
                m_acc = dv && !m_full;
                m_last = 1'b0;
                if (m_fleft > 0) begin
                    m_ser = m_fbits[0];
                    m_fbits = m_fbits >> 1;
                    m_fleft--;
                    m_act = 1'b1;
                    m_last = (m_fleft == 0);
                end else begin
                    m_ser = 1'b1;
                    m_act = 1'b0;
                end
                m_done = m_last;
                if (m_fleft == 0 && (m_full || (m_acc && m_last))) begin
                    m_fbits = frame_of(m_full ? m_word : data);
                    m_fleft = 40;
                    m_full = 1'b0;
                end else if (m_acc) begin
                    m_full = 1'b1;
                    m_word = data;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_on && m_valid) begin
                chk("cmp_serial", ser, m_ser);
                chk("cmp_active", act, m_act);
                chk("cmp_done", done, m_done);
                chk("cmp_ready", rdy, !m_full);
            end
        end
    end

    // Scheduled inputs applied at negedge j; samples taken at negedge j before applying.
    logic [127:0] sch_dv = '0, sch_rst = '1, sch_dvp = '0;
    logic [7:0]   sch_d [128];
    logic [6:0]   sch_d7 [128];
    logic [127:0] s_ser, s_act, s_done, s_rdy;
    logic [127:0] s_pe_ser, s_pe_act, s_pe_done, s_po_ser, s_po_act, s_po_done;

    task automatic run(input int n);
        s_ser = '1; s_act = '0; s_done = '0; s_rdy = '1;
        s_pe_ser = '1; s_pe_act = '0; s_pe_done = '0;
        s_po_ser = '1; s_po_act = '0; s_po_done = '0;
        for (int j = 0; j <= n; j++) begin
            @(negedge clk);
            s_ser[j] = ser; s_act[j] = act; s_done[j] = done; s_rdy[j] = rdy;
            s_pe_ser[j] = pe_ser; s_pe_act[j] = pe_act; s_pe_done[j] = pe_done;
            s_po_ser[j] = po_ser; s_po_act[j] = po_act; s_po_done[j] = po_done;
            dv = sch_dv[j]; data = sch_d[j]; rst_n = sch_rst[j];
            dvp = sch_dvp[j]; d7 = sch_d7[j];
`ifdef UART_TX_BREAK_EN
            brk = sch_brk[j];
`endif
        end
        sch_dv = '0; sch_rst = '1; sch_dvp = '0;
`ifdef UART_TX_BREAK_EN
        sch_brk = '0;
`endif
    endtask

    function automatic int cnt_in(input logic [127:0] v, input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) n += int'(v[i]);
        return n;
    endfunction

    initial begin
        int first_low;
        logic [7:0] a5_bits [8];
        a5_bits = '{1, 0, 1, 0, 0, 1, 0, 1};
        for (int i = 0; i < 128; i++) begin sch_d[i] = '0; sch_d7[i] = '0; end

        repeat (3) @(negedge clk);
        chk("reset_serial", ser, 1'b1);
        chk("reset_active", act, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_ready", rdy, 1'b1);
        rst_n = 1'b1;

        chk("model_frame_A5", frame_of(8'hA5), 40'hFF0F00F0F0);
        chk("model_frame_01", frame_of(8'h01), 40'hF0000000F0);

        // 0xA5 from idle: start bit low at j=3..6, data LSB first, done on j=42
        run(5);
        sch_dv[0] = 1'b1; sch_d[0] = 8'hA5;
        run(50);
        chk("a5_ready_drop", s_rdy[1], 1'b0);
        chk("a5_ready_back", s_rdy[2], 1'b1);
        chk("a5_latency_high", s_ser[2], 1'b1);
        chk("a5_start_first", s_ser[3], 1'b0);
        chk("a5_start_last", s_ser[6], 1'b0);
        for (int b = 0; b < 8; b++) chk("a5_data_bit", s_ser[8 + 4 * b], a5_bits[b][0]);
        chk("a5_stop", s_ser[40], 1'b1);
        chk("a5_active_len", cnt_in(s_act, 0, 50), 40);
        chk("a5_done_count", cnt_in(s_done, 0, 50), 1);
        chk("a5_done_pos", s_done[42], 1'b1);
        chk("a5_active_end", s_act[43], 1'b0);

        // back-to-back 0x01 then 0xFF, third word offered while holding is full
        sch_dv[0] = 1'b1; sch_d[0] = 8'h01;
        sch_dv[10] = 1'b1; sch_d[10] = 8'hFF;
        for (int j = 12; j <= 14; j++) begin sch_dv[j] = 1'b1; sch_d[j] = 8'h3C; end
        run(100);
        chk("b2b_bit1_f1", s_ser[12], 1'b0);
        chk("b2b_ready_full", s_rdy[12], 1'b0);
        chk("b2b_last_stop", s_ser[42], 1'b1);
        chk("b2b_second_start", s_ser[43], 1'b0);
        chk("b2b_bit0_f2", s_ser[48], 1'b1);
        chk("b2b_done_a", s_done[42], 1'b1);
        chk("b2b_done_b", s_done[82], 1'b1);
        chk("b2b_done_count", cnt_in(s_done, 0, 100), 2);
        chk("b2b_active_len", cnt_in(s_act, 3, 82), 80);
        chk("b2b_active_end", s_act[83], 1'b0);

        // word offered on the final stop decision cycle still follows with no gap
        sch_dv[0] = 1'b1; sch_d[0] = 8'h0F;
        sch_dv[41] = 1'b1; sch_d[41] = 8'hF0;
        run(100);
        chk("byp_ready", s_rdy[41], 1'b1);
        chk("byp_start", s_ser[43], 1'b0);
        chk("byp_active_len", cnt_in(s_act, 0, 100), 80);
        chk("byp_done_count", cnt_in(s_done, 0, 100), 2);

        // parity: 0x55 has four ones, 0x07 has three
        sch_dvp[0] = 1'b1; sch_d7[0] = 7'h55;
        run(50);
        chk("par55_bit0", s_pe_ser[8], 1'b1);
        chk("par55_bit1", s_pe_ser[12], 1'b0);
        chk("par55_even", s_pe_ser[36], 1'b0);
        chk("par55_odd", s_po_ser[36], 1'b1);
        chk("par55_even_len", cnt_in(s_pe_act, 0, 50), 40);
        chk("par55_odd_len", cnt_in(s_po_act, 0, 50), 44);
        chk("par55_even_done", s_pe_done[42], 1'b1);
        chk("par55_odd_done", s_po_done[46], 1'b1);
        chk("par55_odd_stop2", s_po_ser[44], 1'b1);
        sch_dvp[0] = 1'b1; sch_d7[0] = 7'h07;
        run(50);
        chk("par07_even", s_pe_ser[36], 1'b1);
        chk("par07_odd", s_po_ser[36], 1'b0);

        // reset during frame cycle 12 with a word pending
        sch_dv[0] = 1'b1; sch_d[0] = 8'h81;
        sch_dv[5] = 1'b1; sch_d[5] = 8'h42;
        sch_rst[14] = 1'b0;
        run(80);
        chk("rst_mid_pre_low", s_ser[13], 1'b0);
        chk("rst_mid_serial", s_ser[15], 1'b1);
        chk("rst_mid_ready", s_rdy[15], 1'b1);
        chk("rst_mid_active", s_act[15], 1'b0);
        chk("rst_mid_no_done", cnt_in(s_done, 15, 80), 0);
        chk("rst_mid_line_idle", cnt_in(~s_ser, 15, 80), 0);

`ifdef UART_TX_BREAK_EN
        model_on = 1'b0;
        sch_dv[0] = 1'b1; sch_d[0] = 8'h3C;
        for (int j = 0; j < 20; j++) sch_brk[j] = 1'b1;
        run(100);
        chk("brk_low_cycles", cnt_in(~s_ser, 1, 20), 20);
        chk("brk_no_active", cnt_in(s_act, 1, 20), 0);
        chk("brk_release", s_ser[21], 1'b1);
        first_low = -1;
        for (int j = 21; j <= 100; j++) if (!s_ser[j] && first_low < 0) first_low = j;
        chk("brk_mark_time", (first_low >= 25), 1'b1);
        chk("brk_frame_done", cnt_in(s_done, 0, 100), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_on = 1'b1;
`else
        first_low = 0;
`endif

        run(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
